// File: rtl/mips_defs.sv
// Shared MIPS core definitions: multiply/divide op codes and MDU FSM encoding.
package mips_defs;

  localparam int unsigned MD_OP_W = 2;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // Width of a down-counter that must hold the larger latency minus one (never zero bits).
  function automatic int unsigned cnt_width(input int unsigned mult_cycles,
                                            input int unsigned div_cycles);
    int unsigned m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide arithmetic feeding the MDU pending-result registers.
module mdu_calc
  import mips_defs::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [MD_OP_W-1:0] md_op,
  output logic [WIDTH-1:0]   res_hi,
  output logic [WIDTH-1:0]   res_lo,
  output logic               div_by_zero
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic             is_signed;
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // Sign-magnitude divide and sign-extended 2*WIDTH multiply, selected by op.
  always_comb begin
    is_signed   = (md_op == MD_MULT) || (md_op == MD_DIV);
    is_div      = (md_op == MD_DIV) || (md_op == MD_DIVU);
    neg_a       = is_signed & a[WIDTH-1];
    neg_b       = is_signed & b[WIDTH-1];
    ext_a       = {{WIDTH{neg_a}}, a};
    ext_b       = {{WIDTH{neg_b}}, b};
    prod        = ext_a * ext_b;
    // Most-negative dividend maps to itself as an unsigned magnitude, so overflow needs no special case.
    mag_a       = neg_a ? (WIDTH'(0) - a) : a;
    mag_b       = neg_b ? (WIDTH'(0) - b) : b;
    div_by_zero = is_div && (b == '0);
    divisor     = (b == '0) ? WIDTH'(1) : mag_b;
    quo         = mag_a / divisor;
    rem         = mag_a % divisor;
    res_hi      = prod[W2-1:WIDTH];
    res_lo      = prod[WIDTH-1:0];
    if (is_div) begin
      res_lo = (neg_a ^ neg_b) ? (WIDTH'(0) - quo) : quo;
      res_hi = neg_a ? (WIDTH'(0) - rem) : rem;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu
  import mips_defs::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         md_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic               busy,
  output logic               stall_req,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  mdu_state_e       state;
  mdu_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_dbz;
  logic             load;
  logic             commit;
  logic             mt_en;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_by_zero;

  mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .a          (a),
    .b          (b),
    .md_op      (md_op),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .div_by_zero(div_by_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_nxt;
  end

  // Next state: launch on start, return to idle on the final count.
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: if (start)      state_nxt = MDU_RUN;
      MDU_RUN:  if (cnt == '0)  state_nxt = MDU_IDLE;
      default:                  state_nxt = MDU_IDLE;
    endcase
  end

  // Control decode; start takes priority over mthi/mtlo in the same cycle.
  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    commit = 1'b0;
    mt_en  = 1'b0;
    case (state)
      MDU_IDLE: begin
        load  = start;
        mt_en = ~start;
      end
      MDU_RUN: begin
        busy   = 1'b1;
        commit = (cnt == '0);
      end
      default: ;
    endcase
  end

  assign stall_req = start | busy;

  // Counter, pending result capture and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      pend_hi  <= '0;
      pend_lo  <= '0;
      pend_dbz <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (load) begin
        cnt      <= md_op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
        pend_hi  <= res_hi;
        pend_lo  <= res_lo;
        pend_dbz <= div_by_zero;
      end else if (busy && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit && !pend_dbz) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      if (mt_en && hi_we) hi <= wdata;
      if (mt_en && lo_we) lo <= wdata;
    end
  end

  // The hazard unit must never issue a new op or an mthi/mtlo while an op is in flight.
  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) busy |-> !start);
  a_no_mt_busy:    assert property (@(posedge clk) disable iff (reset) busy |-> !(hi_we || lo_we));

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .stall_req(stall_req),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero with remainder sign of dividend.
  function automatic void model_calc(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl, output logic dz);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    dz = 1'b0;
    rh = '0;
    rl = '0;
    case (op)
      2'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      2'd2: begin
        if (y == '0) dz = 1'b1;
        else begin p = sx / sy; rl = p[31:0]; p = sx % sy; rh = p[31:0]; end
      end
      default: begin
        if (y == '0) dz = 1'b1;
        else begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
      end
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge after the result commits.
  task automatic run_op(input logic [1:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        input logic with_we);
    logic [31:0] nh, nl;
    logic        dz;
    int          n;
    int          exp_n;
    model_calc(op, oa, ob, nh, nl, dz);
    exp_n = op[1] ? 10 : 5;
    start = 1'b1;
    md_op = op;
    a     = oa;
    b     = ob;
    if (with_we) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = $urandom;
    end
    #1 check("stall_req_on_start", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    md_op = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    n     = 0;
    while (busy && n < 64) begin
      n++;
      check("hi_stable_busy", hi, m_hi);
      check("lo_stable_busy", lo, m_lo);
      check("stall_req_busy", 32'(stall_req), 32'd1);
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(exp_n));
    if (!dz) begin
      m_hi = nh;
      m_lo = nl;
    end
    check("hi_result", hi, m_hi);
    check("lo_result", lo, m_lo);
    check("stall_req_idle", 32'(stall_req), 32'd0);
  endtask

  // mthi/mtlo while idle; visible after one edge.
  task automatic mt_write(input logic wh, input logic wl, input logic [31:0] d);
    hi_we = wh;
    lo_we = wl;
    wdata = d;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (wh) m_hi = d;
    if (wl) m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] ra, rb;
    int          sel;

    reset = 1'b1;
    start = 1'b0;
    md_op = '0;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    m_hi  = '0;
    m_lo  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall_req), 32'd0);

    mt_write(1'b1, 1'b0, 32'h1234);
    run_op(2'd0, 32'hFFFF_FFFD, 32'h5, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_op(2'd3, 32'hFFFF_FFF9, 32'h2, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    mt_write(1'b1, 1'b1, 32'hAA);
    run_op(2'd3, 32'h1234_5678, 32'h0, 1'b0);
    run_op(2'd2, 32'h8765_4321, 32'h0, 1'b0);

    // Reset in the middle of a multiply clears everything immediately.
    start = 1'b1;
    md_op = 2'd0;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("midop_reset_busy", 32'(busy), 32'd0);
    check("midop_reset_hi", hi, 32'h0);
    check("midop_reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_lo", lo, 32'h0);

    // Start together with mthi/mtlo: the writes are dropped.
    run_op(2'd0, 32'd7, 32'd9, 1'b1);

    for (int i = 0; i < 60; i++) begin
      op  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = -32'($urandom_range(0, 100)); rb = -32'($urandom_range(1, 9)); end
        default: ;
      endcase
      if ($urandom_range(0, 4) == 0) mt_write(1'($urandom), 1'($urandom), $urandom);
      run_op(op, ra, rb, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
